// File: rtl/vproc_pkg.sv
// Shared vector-processor types for the FPU arbiter slice.
// Requester IDs are sized for the widest supported requester count.
package vproc_pkg;

    localparam int unsigned FPU_ARB_MAX_REQ      = 4;
    localparam int unsigned FPU_ARB_MAX_INFLIGHT = 4;

    typedef logic [$clog2(FPU_ARB_MAX_REQ)-1:0] fpu_req_id_t;

    // Successor of id in a ring of n requesters.
    function automatic fpu_req_id_t fpu_arb_next_id(
        input fpu_req_id_t id,
        input int unsigned n
    );
        if (int'(id) + 1 >= int'(n)) begin
            return '0;
        end
        return id + fpu_req_id_t'(1);
    endfunction

endpackage

// File: rtl/vproc_fpu_arb_idfifo.sv
// In-flight requester ID FIFO for the FPU arbiter.
// Push on issue, pop on result; flush and reset empty it.
module vproc_fpu_arb_idfifo
    import vproc_pkg::*;
#(
    parameter int unsigned DEPTH = FPU_ARB_MAX_INFLIGHT
) (
    input  logic                     clk_i,
    input  logic                     sync_rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fpu_req_id_t              id_i,
    input  logic                     pop_i,
    output fpu_req_id_t              head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fpu_req_id_t     mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push_ok;
    logic            pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = push_ok ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop_ok  ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= id_i;
            end
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vproc_fpu_arbiter.sv
// Shares one vector FPU pipe between several requesters with round-robin
// issue, locked multi-beat sequences and in-order result routing.
module vproc_fpu_arbiter
    import vproc_pkg::*;
#(
    parameter int unsigned OP_W         = 64,
    parameter int unsigned CTRL_W       = 32,
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned MAX_INFLIGHT = FPU_ARB_MAX_INFLIGHT
) (
    input  logic                          clk_i,
    input  logic                          sync_rst_i,
    input  logic                          flush_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ-1:0]              req_lock_i,
    input  logic [N_REQ*CTRL_W-1:0]       req_ctrl_i,
    input  logic [N_REQ*OP_W-1:0]         req_op1_i,
    input  logic [N_REQ*OP_W-1:0]         req_op2_i,
    input  logic [N_REQ*OP_W-1:0]         req_op3_i,
    input  logic [N_REQ*OP_W/8-1:0]       req_mask_i,
    output logic                          fpu_in_valid_o,
    input  logic                          fpu_in_ready_i,
    output logic [CTRL_W-1:0]             fpu_in_ctrl_o,
    output logic [OP_W-1:0]               fpu_in_op1_o,
    output logic [OP_W-1:0]               fpu_in_op2_o,
    output logic [OP_W-1:0]               fpu_in_op3_o,
    output logic [OP_W/8-1:0]             fpu_in_mask_o,
    input  logic                          fpu_out_valid_i,
    output logic                          fpu_out_ready_o,
    input  logic [OP_W-1:0]               fpu_out_res_i,
    input  logic [CTRL_W-1:0]             fpu_out_ctrl_i,
    output logic [N_REQ-1:0]              res_valid_o,
    input  logic [N_REQ-1:0]              res_ready_i,
    output logic [OP_W-1:0]               res_data_o,
    output logic [CTRL_W-1:0]             res_ctrl_o,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_o,
    output logic                          err_o
);

    localparam int unsigned MW = OP_W / 8;

    logic        lock_q, lock_d;
    fpu_req_id_t owner_q, owner_d;
    fpu_req_id_t rr_q, rr_d;
    logic        err_q, err_d;

    fpu_req_id_t win;
    logic        win_vld;
    logic        fire;
    logic        pop;
    fpu_req_id_t head;
    logic        fifo_full;
    logic        fifo_empty;

    function automatic fpu_req_id_t rr_idx(input fpu_req_id_t base, input int k);
        int i;
        i = int'(base) + k;
        if (i >= int'(N_REQ)) begin
            i = i - int'(N_REQ);
        end
        return fpu_req_id_t'(i);
    endfunction

    // Scan downwards so the lowest rotation offset with a valid wins.
    always_comb begin
        win     = owner_q;
        win_vld = 1'b0;
        if (lock_q) begin
            win_vld = req_valid_i[owner_q];
        end else begin
            win = rr_q;
            for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
                if (req_valid_i[rr_idx(rr_q, k)]) begin
                    win     = rr_idx(rr_q, k);
                    win_vld = 1'b1;
                end
            end
        end
    end

    assign fpu_in_valid_o = win_vld & ~fifo_full & ~sync_rst_i & ~flush_i;
    assign fire           = fpu_in_valid_o & fpu_in_ready_i;

    assign fpu_in_ctrl_o = req_ctrl_i[int'(win)*CTRL_W +: CTRL_W];
    assign fpu_in_op1_o  = req_op1_i[int'(win)*OP_W +: OP_W];
    assign fpu_in_op2_o  = req_op2_i[int'(win)*OP_W +: OP_W];
    assign fpu_in_op3_o  = req_op3_i[int'(win)*OP_W +: OP_W];
    assign fpu_in_mask_o = req_mask_i[int'(win)*MW +: MW];

    always_comb begin
        req_ready_o = '0;
        if (fire) begin
            req_ready_o[win] = 1'b1;
        end
    end

    always_comb begin
        res_valid_o = '0;
        if (!sync_rst_i && !fifo_empty && fpu_out_valid_i) begin
            res_valid_o[head] = 1'b1;
        end
    end

    // Results with nothing tracked are swallowed so the FPU cannot stall.
    assign fpu_out_ready_o = sync_rst_i ? 1'b0 :
                             fifo_empty ? 1'b1 : res_ready_i[head];
    assign pop        = fpu_out_valid_i & fpu_out_ready_o & ~fifo_empty;
    assign res_data_o = fpu_out_res_i;
    assign res_ctrl_o = fpu_out_ctrl_i;
    assign err_o      = err_q;

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        err_d   = err_q | (fpu_out_valid_i & fifo_empty);
        if (flush_i) begin
            lock_d = 1'b0;
        end else if (fire) begin
            lock_d = req_lock_i[win];
            if (req_lock_i[win]) begin
                owner_d = win;
            end else begin
                rr_d = fpu_arb_next_id(win, N_REQ);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    vproc_fpu_arb_idfifo #(
        .DEPTH (MAX_INFLIGHT)
    ) u_idfifo (
        .clk_i      (clk_i),
        .sync_rst_i (sync_rst_i),
        .flush_i    (flush_i),
        .push_i     (fire),
        .id_i       (win),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (inflight_o)
    );

endmodule

// File: tb/tb_vproc_fpu_arbiter.sv
// Randomized bench for vproc_fpu_arbiter against a queue-based
// reference model of arbitration, in-flight tracking and routing.
module tb_vproc_fpu_arbiter;

    localparam int N   = 2;
    localparam int OW  = 64;
    localparam int CW  = 32;
    localparam int MAXI = 4;

    logic            clk = 1'b0;
    logic            sync_rst_i;
    logic            flush_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    req_lock_i;
    logic [N*CW-1:0] req_ctrl_i;
    logic [N*OW-1:0] req_op1_i;
    logic [N*OW-1:0] req_op2_i;
    logic [N*OW-1:0] req_op3_i;
    logic [N*OW/8-1:0] req_mask_i;
    logic            fpu_in_valid_o;
    logic            fpu_in_ready_i;
    logic [CW-1:0]   fpu_in_ctrl_o;
    logic [OW-1:0]   fpu_in_op1_o;
    logic [OW-1:0]   fpu_in_op2_o;
    logic [OW-1:0]   fpu_in_op3_o;
    logic [OW/8-1:0] fpu_in_mask_o;
    logic            fpu_out_valid_i;
    logic            fpu_out_ready_o;
    logic [OW-1:0]   fpu_out_res_i;
    logic [CW-1:0]   fpu_out_ctrl_i;
    logic [N-1:0]    res_valid_o;
    logic [N-1:0]    res_ready_i;
    logic [OW-1:0]   res_data_o;
    logic [CW-1:0]   res_ctrl_o;
    logic [2:0]      inflight_o;
    logic            err_o;

    always #5 clk = ~clk;

    vproc_fpu_arbiter #(
        .OP_W (OW), .CTRL_W (CW), .N_REQ (N), .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk_i           (clk),
        .sync_rst_i      (sync_rst_i),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_lock_i      (req_lock_i),
        .req_ctrl_i      (req_ctrl_i),
        .req_op1_i       (req_op1_i),
        .req_op2_i       (req_op2_i),
        .req_op3_i       (req_op3_i),
        .req_mask_i      (req_mask_i),
        .fpu_in_valid_o  (fpu_in_valid_o),
        .fpu_in_ready_i  (fpu_in_ready_i),
        .fpu_in_ctrl_o   (fpu_in_ctrl_o),
        .fpu_in_op1_o    (fpu_in_op1_o),
        .fpu_in_op2_o    (fpu_in_op2_o),
        .fpu_in_op3_o    (fpu_in_op3_o),
        .fpu_in_mask_o   (fpu_in_mask_o),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .fpu_out_res_i   (fpu_out_res_i),
        .fpu_out_ctrl_i  (fpu_out_ctrl_i),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .res_data_o      (res_data_o),
        .res_ctrl_o      (res_ctrl_o),
        .inflight_o      (inflight_o),
        .err_o           (err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    int q[$];
    bit m_lock;
    int m_own;
    int m_rr;
    bit m_err;

    // Per-phase percentages: valid, lock, in_ready, out_valid, res_ready, flush, reset.
    localparam int NPH = 6;
    int pv  [NPH] = '{100, 100,  90, 100,  70,  80};
    int pl  [NPH] = '{  0,  40,  30,   0,  30,  35};
    int pir [NPH] = '{100, 100,  80, 100,  70,  90};
    int pov [NPH] = '{100,  60,  50,   0,  60,  50};
    int prr [NPH] = '{100, 100,  50, 100,  60,  70};
    int pfl [NPH] = '{  0,   0,   3,   0,   5,   4};
    int prs [NPH] = '{  0,   0,   2,   0,   3,   3};

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    initial begin
        int  w;
        bit  wv, full, empty, exp_iv, fire, exp_or, pop;
        int  exp_rv, exp_rdy;

        sync_rst_i = 1'b1;
        flush_i = 1'b0;
        req_valid_i = '0;
        req_lock_i = '0;
        req_ctrl_i = '0;
        req_op1_i = '0;
        req_op2_i = '0;
        req_op3_i = '0;
        req_mask_i = '0;
        fpu_in_ready_i = 1'b0;
        fpu_out_valid_i = 1'b0;
        fpu_out_res_i = '0;
        fpu_out_ctrl_i = '0;
        res_ready_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_valid", fpu_in_valid_o, 0);
        chk("rst_out_ready", fpu_out_ready_o, 0);
        chk("rst_inflight", inflight_o, 0);
        chk("rst_err", err_o, 0);
        m_lock = 0;
        m_own = 0;
        m_rr = 0;
        m_err = 0;

        for (int p = 0; p < NPH; p++) begin
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    req_valid_i[i] = pct(pv[p]);
                    req_lock_i[i]  = pct(pl[p]);
                    res_ready_i[i] = pct(prr[p]);
                end
                req_ctrl_i = {$urandom, $urandom};
                req_op1_i = {$urandom, $urandom, $urandom, $urandom};
                req_op2_i = {$urandom, $urandom, $urandom, $urandom};
                req_op3_i = {$urandom, $urandom, $urandom, $urandom};
                req_mask_i = 16'($urandom);
                fpu_in_ready_i = pct(pir[p]);
                fpu_out_valid_i = pct(pov[p]);
                fpu_out_res_i = {$urandom, $urandom};
                fpu_out_ctrl_i = $urandom;
                flush_i = pct(pfl[p]);
                sync_rst_i = pct(prs[p]);
                #1;

                // Expected grant: lock owner, else first valid in rotation.
                w = m_own;
                wv = 0;
                if (m_lock) begin
                    wv = req_valid_i[m_own];
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (!wv && req_valid_i[(m_rr + k) % N]) begin
                            w = (m_rr + k) % N;
                            wv = 1;
                        end
                    end
                end
                full = (q.size() == MAXI);
                empty = (q.size() == 0);
                exp_iv = wv && !full && !sync_rst_i && !flush_i;
                fire = exp_iv && fpu_in_ready_i;
                exp_rdy = fire ? (1 << w) : 0;
                exp_rv = (!sync_rst_i && !empty && fpu_out_valid_i) ? (1 << q[0]) : 0;
                exp_or = sync_rst_i ? 0 : (empty ? 1 : res_ready_i[q[0]]);
                pop = fpu_out_valid_i && exp_or && !empty;

                chk("in_valid", fpu_in_valid_o, exp_iv);
                chk("req_ready", req_ready_o, exp_rdy);
                chk("res_valid", res_valid_o, exp_rv);
                chk("out_ready", fpu_out_ready_o, exp_or);
                chk("inflight", inflight_o, q.size());
                chk("err", err_o, m_err);
                if (exp_iv) begin
                    chk("in_ctrl", fpu_in_ctrl_o, req_ctrl_i[w*CW +: CW]);
                    chk("in_op1", fpu_in_op1_o, req_op1_i[w*OW +: OW]);
                    chk("in_op2", fpu_in_op2_o, req_op2_i[w*OW +: OW]);
                    chk("in_op3", fpu_in_op3_o, req_op3_i[w*OW +: OW]);
                    chk("in_mask", fpu_in_mask_o, req_mask_i[w*8 +: 8]);
                end
                if (exp_rv != 0) begin
                    chk("res_data", res_data_o, fpu_out_res_i);
                    chk("res_ctrl", res_ctrl_o, fpu_out_ctrl_i);
                end

                if (sync_rst_i) begin
                    q.delete();
                    m_lock = 0;
                    m_own = 0;
                    m_rr = 0;
                    m_err = 0;
                end else begin
                    if (fpu_out_valid_i && empty) m_err = 1;
                    if (flush_i) begin
                        q.delete();
                        m_lock = 0;
                    end else begin
                        if (pop) void'(q.pop_front());
                        if (fire) begin
                            q.push_back(w);
                            if (req_lock_i[w]) begin
                                m_lock = 1;
                                m_own = w;
                            end else begin
                                m_lock = 0;
                                m_rr = (w + 1) % N;
                            end
                        end
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
